mem_wb_pipe_reg: RTL and testbench
==================================

# mem_wb_pipe_reg

Parametrised MEM/WB pipeline stage register for the MIPS-32 datapath, sitting between the data-memory stage and the write-back mux. It carries read data, ALU result, write-back control, destination register and jump address. Unlike a plain free-running stage register, it has a valid/ready handshake with a 2-entry skid buffer (registered `in_ready`), a flush that inserts a bubble, and optional squashing of writes to `$zero`.

## Interface
- `DATA_W`, 32: width of `Read_data`, `Alu_result`, `jump_address`.
- `WB_W`, 3: width of write-back control field.
- `REG_W`, 5: width of destination register index.
- `REGWRITE_BIT`, 0: index of the register-write enable inside the WB field.
- `ZERO_SQUASH`, 1: 1 = clear `REGWRITE_BIT` when the destination is 0.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `flush`  in  1  discard all held entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept; registered.
- `Read_data`, `Alu_result`, `jump_address`  in  DATA_W each  payload.
- `WB`  in  WB_W  write-back control.
- `direccion`  in  REG_W  destination register.
- `out_valid`  out  1  output entry present.
- `out_ready`  in  1  write-back consumes the entry.
- `Read_data_out`, `Alu_result_out`, `jump_address_out`  out  DATA_W each  payload.
- `WB_out`  out  WB_W  control; all-zero whenever `out_valid`=0.
- `direccion_out`  out  REG_W  destination.
- `count`  out  2  occupancy, 0..2.

## Operation
- accept = `in_valid & in_ready`. issue = `out_valid & out_ready`.
- Storage: main register, which drives the outputs, plus a skid register. State is EMPTY (count 0), ONE (main valid), or FULL (main + skid valid).
- EMPTY: accept → ONE, main ← input.
- ONE:
  - accept & issue → ONE, main ← input.
  - accept & !issue → FULL, skid ← input.
  - issue only → EMPTY.
  - otherwise hold.
- FULL: issue → ONE, main ← skid; otherwise hold. No accept is possible in FULL.
- `in_ready` next = 1 when the next state ≠ FULL.
- On capture into main or skid with `ZERO_SQUASH`=1 and `direccion`==0, the stored WB bit `REGWRITE_BIT` is forced to 0. All other WB bits pass unchanged.
- Priority per edge: reset > flush > handshake.
- flush:
  - Next state EMPTY; `out_valid`, `count` ← 0; `WB_out` ← 0.
  - Payload outputs hold their previous values.
  - An accept coinciding with flush is discarded.
  - `in_ready` ← 1.
- Reset (`rst_n`=0 at an edge): all outputs ← 0, including `in_ready`, `out_valid`, `count` and every payload/WB output; state EMPTY. First edge with `rst_n`=1 sets `in_ready` to 1.
- When `out_valid`=0, `WB_out` is 0 so no spurious register-file write occurs. This holds after issue-to-EMPTY too: WB_out is cleared on that edge.
- Payload is held stable while `out_valid & !out_ready`.

## Timing
- Latency: accept at edge N in EMPTY → `out_valid`=1 with data after edge N, i.e. visible in cycle N+1.
- Throughput: one entry per cycle while `out_ready`=1.
- `out_ready` falling: at most one further entry is absorbed (into skid). `in_ready` drops the cycle after FULL is entered.
- `in_ready` depends only on flops; it has no combinational path from `out_ready`.
- Order is strictly FIFO: main before skid.
- Flush and reset take effect at the same edge they are sampled; no partial-cycle behaviour.

## Test plan
- Reset then stream: `rst_n`=0 for 2 edges → all outputs 0; then `in_ready`=1 after the first high edge. Send Alu_result 0x10,0x11,0x12 with `out_ready`=1 → outputs 0x10,0x11,0x12 on consecutive cycles, `count`=1 throughout.
- Backpressure/skid: stream 0xA0,0xA1,0xA2 with `out_ready`=0 from the second cycle:
  - 0xA0 held in main, 0xA1 in skid, `count`=2, `in_ready`=0, 0xA2 not accepted.
  - Raise `out_ready` → 0xA0, 0xA1, 0xA2 in order, no loss or duplication.
- Flush in FULL: fill to `count`=2, assert `flush` together with `in_valid` (data 0xBB) → next cycle `out_valid`=0, `WB_out`=0, `count`=0, `in_ready`=1; 0xBB never appears.
- Zero squash: `direccion`=0, WB=3'b111 → `WB_out`=3'b110. With `ZERO_SQUASH`=0 → 3'b111. With `direccion`=5 → 3'b111.
- Reset mid-operation: `rst_n`=0 while FULL with `out_ready`=0 → next cycle every output 0, `count`=0; held entries are not emitted after release.
- Random valid/ready (≥10k cycles) against a scoreboard queue: output order and values match, `count` ≤ 2, `WB_out`=0 whenever `out_valid`=0.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB stage register with a valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the outputs and the skid entry absorbs one extra beat
// when write-back stalls. in_ready comes straight from a flop. WB_out is forced
// to zero whenever no entry is presented, so a bubble can never write the
// register file.
module mem_wb_pipe_reg #(
  parameter int DATA_W       = 32,
  parameter int WB_W         = 3,
  parameter int REG_W        = 5,
  parameter int REGWRITE_BIT = 0,
  parameter int ZERO_SQUASH  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] Read_data,
  input  logic [DATA_W-1:0] Alu_result,
  input  logic [DATA_W-1:0] jump_address,
  input  logic [WB_W-1:0]   WB,
  input  logic [REG_W-1:0]  direccion,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] Read_data_out,
  output logic [DATA_W-1:0] Alu_result_out,
  output logic [DATA_W-1:0] jump_address_out,
  output logic [WB_W-1:0]   WB_out,
  output logic [REG_W-1:0]  direccion_out,
  output logic [1:0]        count
);

  typedef struct packed {
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] jmp;
    logic [WB_W-1:0]   wb;
    logic [REG_W-1:0]  dir;
  } ent_t;

  // The encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state;
  ent_t   in_ent, main_q, skid_q;
  logic   accept, issue, nxt_full;

  // Pack the incoming beat; a write to $zero has its register-write bit cleared
  always_comb begin
    in_ent.rd  = Read_data;
    in_ent.alu = Alu_result;
    in_ent.jmp = jump_address;
    in_ent.wb  = WB;
    in_ent.dir = direccion;
    if (ZERO_SQUASH != 0 && direccion == '0) in_ent.wb[REGWRITE_BIT] = 1'b0;
  end

  assign accept = in_valid & in_ready;
  assign issue  = (state != EMPTY) & out_ready;

  // FULL next cycle: either we stay FULL, or ONE takes a beat without issuing
  assign nxt_full = (state == FULL) ? ~issue : ((state == ONE) & accept & ~issue);

  // Occupancy state, storage and registered in_ready
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else if (flush) begin
      // Payload flops keep their values; only the occupancy is dropped
      state    <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      in_ready <= ~nxt_full;
      case (state)
        EMPTY: if (accept) begin
          main_q <= in_ent;
          state  <= ONE;
        end
        ONE: begin
          if (accept && issue) begin
            main_q <= in_ent;
          end else if (accept) begin
            skid_q <= in_ent;
            state  <= FULL;
          end else if (issue) begin
            state  <= EMPTY;
          end
        end
        FULL: if (issue) begin
          main_q <= skid_q;
          state  <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_valid        = (state != EMPTY);
  assign count            = state;
  assign Read_data_out    = main_q.rd;
  assign Alu_result_out   = main_q.alu;
  assign jump_address_out = main_q.jmp;
  assign direccion_out    = main_q.dir;
  assign WB_out           = out_valid ? main_q.wb : '0;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed and random checks for mem_wb_pipe_reg. A second instance has
// zero-squash disabled and shares all inputs with the first.
module tb_mem_wb_pipe_reg;
  localparam int DW = 32, WW = 3, RW = 5;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [DW-1:0] rd, alu, jmp;
  logic [WW-1:0] wb;
  logic [RW-1:0] dir;

  logic          in_ready, out_valid;
  logic [DW-1:0] rd_o, alu_o, jmp_o;
  logic [WW-1:0] wb_o;
  logic [RW-1:0] dir_o;
  logic [1:0]    cnt;

  logic          in_ready2, out_valid2;
  logic [DW-1:0] rd_o2, alu_o2, jmp_o2;
  logic [WW-1:0] wb_o2;
  logic [RW-1:0] dir_o2;
  logic [1:0]    cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_reg #(.DATA_W(DW), .WB_W(WW), .REG_W(RW), .REGWRITE_BIT(0), .ZERO_SQUASH(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .Read_data(rd), .Alu_result(alu), .jump_address(jmp), .WB(wb), .direccion(dir),
    .out_valid(out_valid), .out_ready(out_ready), .Read_data_out(rd_o),
    .Alu_result_out(alu_o), .jump_address_out(jmp_o), .WB_out(wb_o),
    .direccion_out(dir_o), .count(cnt));

  mem_wb_pipe_reg #(.DATA_W(DW), .WB_W(WW), .REG_W(RW), .REGWRITE_BIT(0), .ZERO_SQUASH(0)) dut_nsq (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .Read_data(rd), .Alu_result(alu), .jump_address(jmp), .WB(wb), .direccion(dir),
    .out_valid(out_valid2), .out_ready(out_ready), .Read_data_out(rd_o2),
    .Alu_result_out(alu_o2), .jump_address_out(jmp_o2), .WB_out(wb_o2),
    .direccion_out(dir_o2), .count(cnt2));

  typedef struct {
    logic [DW-1:0] rd, alu, jmp;
    logic [WW-1:0] wb;
    logic [RW-1:0] dir;
  } ent_t;

  ent_t q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat with payload fields derived from the ALU value
  task automatic drive(input logic v, input logic [DW-1:0] a);
    in_valid = v;
    alu      = a;
    rd       = a ^ 32'hFFFF_0000;
    jmp      = a + 32'h100;
    dir      = 5'd1;
    wb       = 3'b101;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irdy"}, in_ready, 0);
    chk({tag, "_ov"},   out_valid, 0);
    chk({tag, "_cnt"},  cnt, 0);
    chk({tag, "_rd"},   rd_o, 0);
    chk({tag, "_alu"},  alu_o, 0);
    chk({tag, "_jmp"},  jmp_o, 0);
    chk({tag, "_wb"},   wb_o, 0);
    chk({tag, "_dir"},  dir_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0);
    #1;

    // reset held for two edges
    tick(); tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();
    chk("rst_rel_irdy", in_ready, 1);
    chk("rst_rel_ov", out_valid, 0);

    // streaming, one per cycle
    out_ready = 1'b1;
    drive(1'b1, 32'h10); tick();
    chk("s0_ov", out_valid, 1); chk("s0_alu", alu_o, 32'h10); chk("s0_cnt", cnt, 1);
    chk("s0_rd", rd_o, 32'hFFFF_0010); chk("s0_jmp", jmp_o, 32'h110);
    chk("s0_wb", wb_o, 3'b101); chk("s0_dir", dir_o, 1);
    drive(1'b1, 32'h11); tick();
    chk("s1_alu", alu_o, 32'h11); chk("s1_cnt", cnt, 1); chk("s1_irdy", in_ready, 1);
    drive(1'b1, 32'h12); tick();
    chk("s2_alu", alu_o, 32'h12); chk("s2_cnt", cnt, 1);
    drive(1'b0, 32'h0); tick();
    chk("s_end_ov", out_valid, 0); chk("s_end_wb", wb_o, 0); chk("s_end_cnt", cnt, 0);

    // backpressure into skid
    drive(1'b1, 32'hA0); tick();
    chk("b0_alu", alu_o, 32'hA0); chk("b0_cnt", cnt, 1);
    out_ready = 1'b0;
    drive(1'b1, 32'hA1); tick();
    chk("b1_alu", alu_o, 32'hA0); chk("b1_cnt", cnt, 2); chk("b1_irdy", in_ready, 0);
    drive(1'b1, 32'hA2); tick();
    chk("b2_alu", alu_o, 32'hA0); chk("b2_cnt", cnt, 2); chk("b2_irdy", in_ready, 0);
    out_ready = 1'b1; tick();
    chk("b3_alu", alu_o, 32'hA1); chk("b3_cnt", cnt, 1); chk("b3_irdy", in_ready, 1);
    tick();
    chk("b4_alu", alu_o, 32'hA2); chk("b4_cnt", cnt, 1);
    drive(1'b0, 32'h0); tick();
    chk("b5_ov", out_valid, 0);

    // flush in FULL discards held entries and the coincident beat
    out_ready = 1'b0;
    drive(1'b1, 32'hC0); tick();
    drive(1'b1, 32'hC1); tick();
    chk("f_pre_cnt", cnt, 2);
    flush = 1'b1; drive(1'b1, 32'hBB); tick();
    chk("f_ov", out_valid, 0); chk("f_wb", wb_o, 0); chk("f_cnt", cnt, 0);
    chk("f_irdy", in_ready, 1); chk("f_hold_alu", alu_o, 32'hC0);
    flush = 1'b0; drive(1'b0, 32'h0); out_ready = 1'b1; tick();
    chk("f_post_ov", out_valid, 0); chk("f_post_alu", alu_o, 32'hC0);

    // zero-register squash
    drive(1'b1, 32'h55); dir = 5'd0; wb = 3'b111; tick();
    chk("zs_sq", wb_o, 3'b110); chk("zs_nosq", wb_o2, 3'b111);
    drive(1'b1, 32'h56); dir = 5'd5; wb = 3'b111; tick();
    chk("zs5_sq", wb_o, 3'b111); chk("zs5_nosq", wb_o2, 3'b111);
    drive(1'b0, 32'h0); tick();
    chk("zs_end_wb", wb_o, 0);

    // reset while FULL
    out_ready = 1'b0;
    drive(1'b1, 32'hD0); tick();
    drive(1'b1, 32'hD1); tick();
    chk("rm_pre_cnt", cnt, 2);
    drive(1'b0, 32'h0); rst_n = 1'b0; tick();
    chk_all_zero("rm");
    rst_n = 1'b1; out_ready = 1'b1; tick();
    chk("rm_rel_ov", out_valid, 0); chk("rm_rel_irdy", in_ready, 1);
    tick();
    chk("rm_rel2_ov", out_valid, 0);

    // random valid/ready against a scoreboard queue
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic acc, iss;
      ent_t e;
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 60);
      rd  = $urandom; alu = $urandom; jmp = $urandom;
      wb  = WW'($urandom); dir = RW'($urandom_range(0, 3));
      acc = in_valid & in_ready;
      iss = out_valid & out_ready;
      chk("r_cnt", cnt, q.size());
      if (out_valid && q.size() > 0) begin
        chk("r_alu", alu_o, q[0].alu);
        chk("r_rd",  rd_o,  q[0].rd);
        chk("r_jmp", jmp_o, q[0].jmp);
        chk("r_wb",  wb_o,  q[0].wb);
        chk("r_dir", dir_o, q[0].dir);
      end else if (!out_valid) begin
        chk("r_wb_idle", wb_o, 0);
      end
      if (iss && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        e.rd = rd; e.alu = alu; e.jmp = jmp; e.dir = dir;
        e.wb = (dir == 0) ? (wb & 3'b110) : wb;
        q.push_back(e);
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
